// File: rtl/flit_serializer.sv
// Drains 64-bit words from the shared-clock FIFO head and sends each one as
// NPHIT phits of PHIT_W bits over a valid/ready link, least-significant phit first.
module flit_serializer #(
    parameter int PHIT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [63:0]       fifo_data,
    output logic              fifo_rd_en,
    output logic              link_valid,
    output logic [PHIT_W-1:0] link_data,
    output logic              link_last,
    input  logic              link_ready,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int NPHIT = 64 / PHIT_W;
    localparam int CNT_W = (NPHIT > 1) ? $clog2(NPHIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPHIT - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [63:0]      sh;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             final_phit;
    logic             word_done;
    logic             load;
    logic [63:0]      sh_next;
    logic [CNT_W-1:0] cnt_next;

    assign accept     = link_valid && link_ready;
    assign final_phit = (cnt == LAST_CNT);
    assign word_done  = (state == SEND) && accept && final_phit;

    // NOTE: load is gated by reset so the pop strobe can never fire while the
    // block is being cleared; a pop in that cycle would lose a FIFO entry.
    assign load       = !reset && enable && !fifo_empty && (state == IDLE || word_done);

    assign fifo_rd_en = load;
    assign busy       = (state == SEND);
    assign sh_next    = sh >> PHIT_W;
    assign cnt_next   = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            link_valid <= 1'b0;
            link_data  <= '0;
            link_last  <= 1'b0;
            words_sent <= '0;
        end else begin
            if (word_done) begin
                words_sent <= words_sent + 16'd1;
            end

            if (load) begin
                // A follow-on word loads on the same edge as the final phit is taken.
                state      <= SEND;
                sh         <= fifo_data;
                cnt        <= '0;
                link_valid <= 1'b1;
                link_data  <= fifo_data[PHIT_W-1:0];
                link_last  <= (NPHIT == 1);
            end else if (state == SEND && accept) begin
                if (final_phit) begin
                    state      <= IDLE;
                    link_valid <= 1'b0;
                    link_last  <= 1'b0;
                end else begin
                    sh         <= sh_next;
                    cnt        <= cnt_next;
                    link_data  <= sh_next[PHIT_W-1:0];
                    link_last  <= (cnt_next == LAST_CNT);
                end
            end
        end
    end

endmodule

// File: tb/tb_flit_serializer.sv
// Directed bench for flit_serializer: three instances (16-, 8- and 64-bit phits),
// each fed by its own small FIFO model sharing enable, link_ready and reset.
module tb_flit_serializer;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic link_ready;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // FIFO model for the 16-bit instance
    logic [63:0] mem16 [64];
    int          wr16 = 0;
    int          rd16_ptr = 0;
    logic        empty16, rd16, v16, l16, b16, uf16 = 1'b0;
    logic [63:0] fdata16;
    logic [15:0] d16, ws16;
    assign empty16 = (wr16 == rd16_ptr);
    assign fdata16 = mem16[rd16_ptr % 64];
    always @(posedge clk) begin
        if (rd16) rd16_ptr <= rd16_ptr + 1;
        if (rd16 && empty16) uf16 <= 1'b1;
    end

    // FIFO model for the 8-bit instance
    logic [63:0] mem8 [64];
    int          wr8 = 0;
    int          rd8_ptr = 0;
    logic        empty8, rd8, v8, l8, b8, uf8 = 1'b0;
    logic [63:0] fdata8;
    logic [7:0]  d8;
    logic [15:0] ws8;
    assign empty8 = (wr8 == rd8_ptr);
    assign fdata8 = mem8[rd8_ptr % 64];
    always @(posedge clk) begin
        if (rd8) rd8_ptr <= rd8_ptr + 1;
        if (rd8 && empty8) uf8 <= 1'b1;
    end

    // Counting word source for the 64-bit instance: word k is {0x12345678, k}
    int          n_push64 = 0;
    int          n_pop64 = 0;
    logic        empty64, rd64, v64, l64, b64, uf64 = 1'b0;
    logic [63:0] fdata64, d64;
    logic [15:0] ws64;
    assign empty64 = (n_push64 == n_pop64);
    assign fdata64 = {32'h1234_5678, 32'(n_pop64)};
    always @(posedge clk) begin
        if (rd64) n_pop64 <= n_pop64 + 1;
        if (rd64 && empty64) uf64 <= 1'b1;
    end

    flit_serializer #(.PHIT_W(16)) u16 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empty16),
        .fifo_data(fdata16), .fifo_rd_en(rd16), .link_valid(v16), .link_data(d16),
        .link_last(l16), .link_ready(link_ready), .busy(b16), .words_sent(ws16)
    );

    flit_serializer #(.PHIT_W(8)) u8 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empty8),
        .fifo_data(fdata8), .fifo_rd_en(rd8), .link_valid(v8), .link_data(d8),
        .link_last(l8), .link_ready(link_ready), .busy(b8), .words_sent(ws8)
    );

    flit_serializer #(.PHIT_W(64)) u64 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(empty64),
        .fifo_data(fdata64), .fifo_rd_en(rd64), .link_valid(v64), .link_data(d64),
        .link_last(l64), .link_ready(link_ready), .busy(b64), .words_sent(ws64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push16(input logic [63:0] w);
        mem16[wr16 % 64] = w;
        wr16 = wr16 + 1;
    endtask

    // One row = inputs for this cycle plus the outputs expected before the next edge
    typedef struct packed {
        logic        ready;
        logic        push;
        logic [63:0] word;
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
    } vec_t;

    localparam logic [63:0] WA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WE = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] WF = 64'h0F0F_1E1E_2D2D_3C3C;

    vec_t        vecs [20];
    logic [63:0] wq [3];
    logic [63:0] w;
    logic [7:0]  exp8 [8];
    logic        saw_ffff;

    initial begin
        // Single word, then a word with ready toggling and a follow-on word queued
        vecs[0]  = '{1'b1, 1'b1, WA,    1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'hCDEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h89AB, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h4567, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, WE,    1'b1, 1'b0, 16'h0123, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, WF,    1'b0, 1'b1, 16'h3210, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 16'h7654, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 16'h7654, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h7654, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 16'hBA98, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'hBA98, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 16'hFEDC, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 16'hFEDC, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h3C3C, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h2D2D, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h1E1E, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0};

        exp8 = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        saw_ffff = 1'b0;

        reset = 1'b1;
        enable = 1'b0;
        link_ready = 1'b0;
        tick();
        tick();
        check("rst.valid_in_reset", 64'(v16), 64'h0);
        reset = 1'b0;
        #1;
        check("rst.valid", 64'(v16), 64'h0);
        check("rst.data",  64'(d16), 64'h0);
        check("rst.last",  64'(l16), 64'h0);
        check("rst.busy",  64'(b16), 64'h0);
        check("rst.words", 64'(ws16), 64'h0);
        check("rst.rd_en", 64'(rd16), 64'h0);
        tick();

        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            link_ready = vecs[i].ready;
            if (vecs[i].push) push16(vecs[i].word);
            #1;
            check($sformatf("tbl[%0d].rd_en", i), 64'(rd16), 64'(vecs[i].exp_rd));
            check($sformatf("tbl[%0d].valid", i), 64'(v16), 64'(vecs[i].exp_valid));
            check($sformatf("tbl[%0d].data", i),  64'(d16), 64'(vecs[i].exp_data));
            check($sformatf("tbl[%0d].last", i),  64'(l16), 64'(vecs[i].exp_last));
            check($sformatf("tbl[%0d].busy", i),  64'(b16), 64'(vecs[i].exp_busy));
            tick();
        end
        check("tbl.words", 64'(ws16), 64'd3);

        // Three back-to-back words: 12 valid cycles, pops at cycles 0, 4 and 8
        wq = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
        link_ready = 1'b1;
        for (int k = 0; k < 3; k++) push16(wq[k]);
        for (int c = 0; c < 14; c++) begin
            #1;
            check($sformatf("b2b[%0d].rd_en", c), 64'(rd16), 64'(c == 0 || c == 4 || c == 8));
            check($sformatf("b2b[%0d].valid", c), 64'(v16), 64'(c >= 1 && c <= 12));
            if (c >= 1 && c <= 12) begin
                w = wq[(c - 1) / 4] >> (16 * ((c - 1) % 4));
                check($sformatf("b2b[%0d].data", c), 64'(d16), 64'(w[15:0]));
                check($sformatf("b2b[%0d].last", c), 64'(l16), 64'(c % 4 == 0));
            end
            tick();
        end
        check("b2b.words", 64'(ws16), 64'd6);

        // enable drops while phit 1 is on the link; word finishes, two stay queued
        push16(64'hAAAA_BBBB_CCCC_DDDD);
        push16(64'h1357_9BDF_2468_ACE0);
        push16(64'hDEAD_BEEF_CAFE_F00D);
        wq[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) enable = 1'b0;
            #1;
            check($sformatf("en[%0d].rd_en", c), 64'(rd16), 64'(c == 0));
            check($sformatf("en[%0d].valid", c), 64'(v16), 64'(c >= 1 && c <= 4));
            check($sformatf("en[%0d].busy", c),  64'(b16), 64'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                w = wq[0] >> (16 * (c - 1));
                check($sformatf("en[%0d].data", c), 64'(d16), 64'(w[15:0]));
            end
            tick();
        end
        check("en.fifo_left", 64'(wr16 - rd16_ptr), 64'd2);
        check("en.words", 64'(ws16), 64'd7);

        // Reset lands mid-word after phit 2; the next queued word starts clean
        enable = 1'b1;
        #1;
        check("mid.rd_en", 64'(rd16), 64'h1);
        tick();
        check("mid.p0", 64'(d16), 64'hACE0);
        tick();
        check("mid.p1", 64'(d16), 64'h2468);
        tick();
        check("mid.p2", 64'(d16), 64'h9BDF);
        #1;
        reset = 1'b1;
        #1;
        check("mid.rst_valid", 64'(v16), 64'h0);
        check("mid.rst_data",  64'(d16), 64'h0);
        check("mid.rst_last",  64'(l16), 64'h0);
        check("mid.rst_busy",  64'(b16), 64'h0);
        check("mid.rst_words", 64'(ws16), 64'h0);
        check("mid.rst_rd_en", 64'(rd16), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        check("mid.restart_rd_en", 64'(rd16), 64'h1);
        tick();
        check("mid.restart_p0",   64'(d16), 64'hF00D);
        check("mid.restart_busy", 64'(b16), 64'h1);
        tick();
        check("mid.restart_p1", 64'(d16), 64'hCAFE);
        tick();
        check("mid.restart_p2", 64'(d16), 64'hBEEF);
        tick();
        check("mid.restart_p3",   64'(d16), 64'hDEAD);
        check("mid.restart_last", 64'(l16), 64'h1);
        tick();
        check("mid.end_valid", 64'(v16), 64'h0);
        check("mid.end_words", 64'(ws16), 64'd1);
        check("mid.fifo_left", 64'(wr16 - rd16_ptr), 64'd0);

        // 8-bit phits: eight phits, last only on the final byte
        mem8[wr8 % 64] = WA;
        wr8 = wr8 + 1;
        #1;
        check("p8.rd_en", 64'(rd8), 64'h1);
        tick();
        for (int j = 0; j < 8; j++) begin
            check($sformatf("p8[%0d].valid", j), 64'(v8), 64'h1);
            check($sformatf("p8[%0d].data", j),  64'(d8), 64'(exp8[j]));
            check($sformatf("p8[%0d].last", j),  64'(l8), 64'(j == 7));
            check($sformatf("p8[%0d].rd_en", j), 64'(rd8), 64'h0);
            tick();
        end
        check("p8.end_valid", 64'(v8), 64'h0);
        check("p8.end_busy",  64'(b8), 64'h0);
        check("p8.words",     64'(ws8), 64'd1);

        // 64-bit phits: one phit per word, last and rd_en every cycle when back-to-back
        n_push64 = 3;
        #1;
        check("p64.c0_rd_en", 64'(rd64), 64'h1);
        check("p64.c0_valid", 64'(v64), 64'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("p64[%0d].data", k),  d64, {32'h1234_5678, 32'(k)});
            check($sformatf("p64[%0d].last", k),  64'(l64), 64'h1);
            check($sformatf("p64[%0d].rd_en", k), 64'(rd64), 64'(k < 2));
            tick();
        end
        check("p64.end_valid", 64'(v64), 64'h0);
        check("p64.end_last",  64'(l64), 64'h0);
        check("p64.words",     64'(ws64), 64'd3);

        // Counter wrap: 65536 words in total take words_sent through 0xFFFF back to 0
        n_push64 = 65536;
        for (int c = 0; c < 70000 && !(n_pop64 == 65536 && !b64); c++) begin
            if (ws64 == 16'hFFFF) saw_ffff = 1'b1;
            tick();
        end
        check("wrap.all_popped", 64'(n_pop64), 64'd65536);
        check("wrap.saw_ffff",   64'(saw_ffff), 64'h1);
        check("wrap.words",      64'(ws64), 64'h0);

        check("pop_when_empty16", 64'(uf16), 64'h0);
        check("pop_when_empty8",  64'(uf8),  64'h0);
        check("pop_when_empty64", 64'(uf64), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/flit_serializer.md
# flit_serializer

Downstream drain stage for the 32×64-bit general-purpose FIFO. It pops 64-bit words from the FIFO head and serializes each one into PHIT_W-bit phits on a narrow NoC link using a valid/ready handshake. Phits go out least-significant first, and consecutive words are sent with no bubble. The FIFO and this block share one clock domain.

## Interface
- PHIT_W, 16, link phit width; legal values 8, 16, 32, 64.
- NPHIT = 64/PHIT_W, derived; not overridable.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  permits starting new words; an in-flight word always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  64  FIFO head word, combinational from the FIFO, valid when fifo_empty=0.
- fifo_rd_en  output  1  pop strobe, combinational, one cycle per word.
- link_valid  output  1  phit valid.
- link_data  output  PHIT_W  current phit.
- link_last  output  1  high with the final phit of a word.
- link_ready  input  1  downstream accepts the phit when valid && ready.
- busy  output  1  state == SEND.
- words_sent  output  16  count of fully transmitted words; wraps 0xFFFF→0x0000.

## Operation
- Internal state: FSM {IDLE, SEND}, shift register sh[63:0], phit counter cnt of width clog2(NPHIT), minimum 1 bit.
- Define accept = link_valid && link_ready.
- Define final = (cnt == NPHIT-1).
- Define load = !reset && enable && !fifo_empty && (state==IDLE || (state==SEND && accept && final)).
- fifo_rd_en = load. It never asserts while fifo_empty=1 or reset=1, so the FIFO error flag can never be raised by this block.
- On load:
  - sh ← fifo_data, cnt ← 0, state ← SEND.
  - link_valid ← 1, link_data ← fifo_data[PHIT_W-1:0].
  - link_last ← (NPHIT==1).
- SEND with accept and !final:
  - sh shifts right by PHIT_W, cnt ← cnt+1.
  - link_data ← next slice, i.e. bits [(cnt+1)·PHIT_W +: PHIT_W] of the loaded word.
  - link_last ← (cnt+1 == NPHIT-1).
- SEND with accept and final:
  - words_sent increments.
  - If load is also true, the next word is loaded in the same edge.
  - Otherwise state ← IDLE, link_valid ← 0, link_last ← 0. link_data holds its last value.
- SEND without accept: link_valid, link_data, link_last and cnt are all held stable. This is an AXI-style rule: once valid is high, data may not change until accepted.
- enable low: the current word drains normally, then the block idles. A word is never abandoned mid-way.
- Reset, including mid-word: all state clears immediately. The partially sent word is dropped, and the FIFO entry was already popped.

## Timing
- Reset values:
  - link_valid=0, link_data=0, link_last=0.
  - busy=0, words_sent=0.
  - fifo_rd_en=0.
  - state=IDLE, cnt=0, sh=0.
- Pop-to-link latency: fifo_rd_en high in cycle t puts phit 0 on the link in cycle t+1.
- Throughput with link_ready held high: NPHIT cycles per word. Back-to-back words show no idle cycle between the last phit of word n and phit 0 of word n+1.
- Pop rate: fifo_rd_en pulses at most once every NPHIT cycles while in SEND, and never in two consecutive cycles unless NPHIT==1.
- FIFO pointer update and the block's load happen on the same edge. fifo_data is sampled in the load cycle only.
- busy rises the cycle after the first load. It falls the cycle after the final phit is accepted with no follow-on load.

## Test plan
- Reset, then FIFO gets 0x0123_4567_89AB_CDEF with link_ready=1 and PHIT_W=16:
  - fifo_rd_en pulses once.
  - Phits 0xCDEF, 0x89AB, 0x4567, 0x0123 appear on 4 consecutive cycles, with link_last only on 0x0123.
  - words_sent=1, then IDLE.
- Three words queued with ready=1: 12 consecutive valid cycles, no gap, 3 rd_en pulses spaced 4 cycles apart, words_sent=3.
- link_ready toggled 1,0,0,1,0,1,1 during a word: link_data and link_last stay frozen while ready=0, no phit is skipped or duplicated, and no rd_en pulse occurs until the final phit is accepted.
- enable dropped after phit 1 of a word with 2 more words queued: the current word completes, then no further rd_en; the FIFO keeps 2 entries and busy=0.
- Reset asserted mid-word after phit 2: outputs go to reset values asynchronously. After release, the next queued word starts cleanly at phit 0 and words_sent=0.
- Preload words_sent=0xFFFF by sending 65535 words (or via force), then send 1 word: words_sent=0x0000. Repeat the first scenario with PHIT_W=8 (8 phits) and PHIT_W=64 (1 phit, link_last every cycle, rd_en every cycle for back-to-back words).
